// File: rtl/fp_div_pkg.sv
// Shared constants and FSM encoding for the iterative FP mantissa divider.
package fp_div_pkg;

  localparam int EXP_WIDTH  = 8;
  localparam int MANT_WIDTH = 23;
  localparam int EXP_BIAS   = 127;
  localparam int CNT_WIDTH  = $clog2(MANT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/fp_div_mant_iter_if.sv
// Start/done handshake, operand and result bundle for fp_div_mant_iter.
interface fp_div_mant_iter_if #(
  parameter int EXP_WIDTH  = fp_div_pkg::EXP_WIDTH,
  parameter int MANT_WIDTH = fp_div_pkg::MANT_WIDTH
);

  logic                  in_Start;
  logic [EXP_WIDTH-1:0]  in_ExpA;
  logic [EXP_WIDTH-1:0]  in_ExpB;
  logic [MANT_WIDTH:0]   in_MantA;
  logic [MANT_WIDTH:0]   in_MantB;

  logic                  out_Busy;
  logic                  out_Done;
  logic [EXP_WIDTH-1:0]  out_Exp;
  logic [MANT_WIDTH:0]   out_Mant;
  logic                  out_Sticky;
  logic                  out_ExpOvf;
  logic                  out_ExpUdf;
  logic                  out_DivZero;

  modport master (
    output in_Start, in_ExpA, in_ExpB, in_MantA, in_MantB,
    input  out_Busy, out_Done, out_Exp, out_Mant, out_Sticky,
           out_ExpOvf, out_ExpUdf, out_DivZero
  );

  modport slave (
    input  in_Start, in_ExpA, in_ExpB, in_MantA, in_MantB,
    output out_Busy, out_Done, out_Exp, out_Mant, out_Sticky,
           out_ExpOvf, out_ExpUdf, out_DivZero
  );

endinterface

// File: rtl/fp_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module fp_div_step #(
  parameter int W = fp_div_pkg::MANT_WIDTH + 2
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] d,
  output logic         q_bit,
  output logic [W-1:0] r_next
);

  logic [W-1:0] diff;

  assign q_bit  = (r >= d);
  assign diff   = r - d;
  assign r_next = (q_bit ? diff : r) << 1;

endmodule

// File: rtl/fp_div_mant_iter.sv
// Iterative restoring mantissa divider: one quotient bit per cycle, MSB first,
// with biased exponent, range flags, sticky and divide-by-zero reporting.
module fp_div_mant_iter #(
  parameter int EXP_WIDTH  = fp_div_pkg::EXP_WIDTH,
  parameter int MANT_WIDTH = fp_div_pkg::MANT_WIDTH,
  parameter int EXP_BIAS   = fp_div_pkg::EXP_BIAS
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_div_mant_iter_if.slave  bus
);

  import fp_div_pkg::*;

  localparam int CNT_W = $clog2(MANT_WIDTH + 1);
  localparam int RW    = MANT_WIDTH + 2;
  localparam int EW    = EXP_WIDTH + 2;
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_WIDTH) - 2);

  state_t state_reg, state_next;

  logic [MANT_WIDTH:0]  d_reg;
  logic [MANT_WIDTH:0]  q_reg;
  logic [MANT_WIDTH:0]  q_next;
  logic [RW-1:0]        r_reg;
  logic [RW-1:0]        r_step;
  logic [CNT_W-1:0]     cnt_reg;
  logic [EXP_WIDTH-1:0] exp_reg;
  logic                 sticky_reg;
  logic                 ovf_reg;
  logic                 udf_reg;
  logic                 divz_reg;

  logic                 q_bit;
  logic                 accept;
  logic                 mant_b_zero;
  logic signed [EW-1:0] e_full;

  assign accept      = (state_reg == IDLE) && bus.in_Start;
  assign mant_b_zero = (bus.in_MantB == '0);

  // Wide enough that ExpA-ExpB+bias never wraps, so the flags see the true value.
  assign e_full = $signed({2'b00, bus.in_ExpA}) - $signed({2'b00, bus.in_ExpB})
                + $signed(EW'(EXP_BIAS));

  fp_div_step #(.W(RW)) u_step (
    .r      (r_reg),
    .d      ({1'b0, d_reg}),
    .q_bit  (q_bit),
    .r_next (r_step)
  );

  genvar gi;
  generate
    for (gi = 0; gi <= MANT_WIDTH; gi++) begin : g_qbit
      assign q_next[gi] = (cnt_reg == CNT_W'(gi)) ? q_bit : q_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_Start) state_next = mant_b_zero ? FINISH : RUN;
      RUN:     if (cnt_reg == '0) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg      <= '0;
      q_reg      <= '0;
      r_reg      <= '0;
      cnt_reg    <= '0;
      exp_reg    <= '0;
      sticky_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
      divz_reg   <= 1'b0;
    end else if (accept) begin
      d_reg      <= bus.in_MantB;
      r_reg      <= {1'b0, bus.in_MantA};
      cnt_reg    <= CNT_W'(MANT_WIDTH);
      exp_reg    <= e_full[EXP_WIDTH-1:0];
      ovf_reg    <= (e_full > E_MAX);
      udf_reg    <= e_full[EW-1] || (e_full == '0);
      divz_reg   <= mant_b_zero;
      q_reg      <= mant_b_zero ? '1 : '0;
      sticky_reg <= 1'b0;
    end else if (state_reg == RUN) begin
      r_reg <= r_step;
      q_reg <= q_next;
      if (cnt_reg == '0) begin
        // Last step: the shifted remainder is nonzero exactly when the true one is.
        sticky_reg <= (r_step != '0);
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  assign bus.out_Busy    = (state_reg != IDLE);
  assign bus.out_Done    = (state_reg == FINISH);
  assign bus.out_Exp     = exp_reg;
  assign bus.out_Mant    = q_reg;
  assign bus.out_Sticky  = sticky_reg;
  assign bus.out_ExpOvf  = ovf_reg;
  assign bus.out_ExpUdf  = udf_reg;
  assign bus.out_DivZero = divz_reg;

endmodule
